program_loader: RTL
===================

Name: program_loader

Overview:
Synthesisable program-load and run-control block for the single-cycle MIPS CPU.
- Holds the CPU in reset while it streams instruction words into the instruction memory over a valid/ready handshake.
- Releases the CPU and counts run cycles against a programmable budget.
- Detects a jump-to-self halt.
- Freezes the CPU and reports done, timeout or halted, so a fixed-duration bench run becomes a self-terminating, reloadable one.

Parameters:
INSTR_MEM_SIZE, 32, instruction memory depth in words; address width AW = clog2(INSTR_MEM_SIZE)
DATA_WIDTH, 32, instruction word width
BUDGET_WIDTH, 16, width of cycle budget and run counter
HALT_DETECT, 1, 1 = stop when PC repeats; 0 = stop on budget only

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 resets the block
start  in  1  single-cycle pulse; begins a load from IDLE or DONE
cycle_budget  in  BUDGET_WIDTH  max run cycles, sampled when start is accepted; 0 = unlimited
load_valid  in  1  load_data is valid
load_ready  out  1  block accepts a word this cycle
load_data  in  DATA_WIDTH  instruction word
load_last  in  1  qualifies the final word of the program
imem_we  out  1  instruction memory write enable
imem_addr  out  AW  instruction memory write address
imem_wdata  out  DATA_WIDTH  instruction memory write data
cpu_reset  out  1  active-low reset to the CPU
cpu_enable  out  1  CPU clock-enable; 1 only in RUN
cpu_pc  in  32  current CPU program counter
done  out  1  run finished
timeout  out  1  run ended on budget
halted  out  1  run ended on PC repeat
words_loaded  out  AW+1  count of words written
run_cycles  out  BUDGET_WIDTH  cycles spent in RUN

Behaviour:
- Reset values (asynchronous, reset=0): state IDLE; load_ready=0, imem_we=0, imem_addr=0, cpu_reset=0, cpu_enable=0, done=0, timeout=0, halted=0, words_loaded=0, run_cycles=0.
- Reset asserted mid-operation aborts immediately. Partially loaded memory contents are left as is.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - cpu_reset=0.
  - start -> LOAD; clears counters and flags, latches cycle_budget.
- LOAD:
  - load_ready=1; cpu_reset=0.
  - Write is combinational: imem_we = load_valid & load_ready; imem_addr = write pointer; imem_wdata = load_data.
  - Each accepted word increments the pointer and words_loaded.
  - Exit to RUN on the next edge when an accepted word has load_last=1, or when the pointer reaches INSTR_MEM_SIZE (memory full).
  - load_last on the final slot gives a single transition. Pointer never wraps.
  - load_valid without load_last after full is not accepted (load_ready=0 in RUN).
- RUN:
  - load_ready=0; cpu_reset=1 and cpu_enable=1, registered, so the first CPU edge is one cycle after the last write.
  - run_cycles increments every cycle and saturates at all-ones.
  - Budget stop: budget nonzero and run_cycles+1 == budget -> DONE with timeout=1. The CPU therefore executes exactly `budget` enabled cycles.
  - Halt stop (HALT_DETECT=1): cpu_pc equals the previous-cycle cpu_pc and prev_valid=1 -> DONE with halted=1. prev_valid clears on RUN entry and sets after the first RUN cycle.
  - Halt and budget in the same cycle: halted=1, timeout=0.
- DONE:
  - cpu_enable=0 freezes CPU state for inspection; cpu_reset stays 1 so registers and PC are preserved.
  - done=1; flags and counters hold.
  - start -> LOAD (reload); the CPU is reset again.
- start is ignored in LOAD and RUN.
- Counters are unsigned; there is no arithmetic other than increment and compare.

Decomposition:
- Shared package/header: FSM state encoding (2-bit localparams), clog2 function, and the halt/timeout flag bit positions.
- One natural sub-module, halt_detector: prev_pc register, prev_valid, compare. The FSM, pointer and counters stay in program_loader.

Test Plan:
- Basic load: start, 4 words 0x20010005.. with load_last on word 4 -> imem_we high 4 cycles at addr 0..3; words_loaded=4; cpu_reset rises 1 cycle after the last write.
- Timeout: budget=10, program without self-loop -> DONE after exactly 10 RUN cycles; timeout=1, halted=0, run_cycles=10, cpu_enable=0.
- Halt: budget=0, program ending in `j .` at addr 3 -> halted=1 on the second consecutive PC=0x0C; timeout=0.
- Full memory: 32 words, no load_last, load_valid held -> 32 writes, addr 31 last; load_ready=0 thereafter; words_loaded=32.
- Backpressure/idle gaps: load_valid toggled every other cycle -> only handshake cycles write; addresses are contiguous.
- Reset mid-run and reload: reset=0 during RUN -> all outputs at reset values at once; after release, start again -> fresh load; start pulsed during RUN is ignored.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: run-control state encoding,
// result flag bit positions and an address-width helper.
package program_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int FLAG_HALT    = 0;
  localparam int FLAG_TIMEOUT = 1;
  localparam int FLAG_W       = 2;

  // Minimum of 1 so a single-word memory still gets a 1-bit address.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/program_loader_halt_detector.sv
// Flags a jump-to-self: the CPU PC equals its value from the previous RUN cycle.
module program_loader_halt_detector #(
  parameter int ENABLE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        active_i,
  input  logic [31:0] pc_i,
  output logic        halt_o
);

  logic [31:0] prev_pc_q;
  logic        prev_valid_q;

  // prev_valid drops whenever the CPU is not running, so each run starts clean.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_pc_q    <= '0;
      prev_valid_q <= 1'b0;
    end else if (active_i) begin
      prev_pc_q    <= pc_i;
      prev_valid_q <= 1'b1;
    end else begin
      prev_valid_q <= 1'b0;
    end
  end

  assign halt_o = (ENABLE != 0) && prev_valid_q && (pc_i == prev_pc_q);

endmodule

// File: rtl/program_loader.sv
// Program-load and run-control for the single-cycle MIPS CPU.
// state | meaning
// IDLE  | CPU in reset, waiting for start
// LOAD  | CPU in reset, streaming words into instruction memory
// RUN   | CPU released and enabled, counting cycles against the budget
// DONE  | CPU frozen (enabled off, reset off), result flags valid
module program_loader
  import program_loader_pkg::*;
#(
  parameter int INSTR_MEM_SIZE = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BUDGET_WIDTH   = 16,
  parameter int HALT_DETECT    = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [BUDGET_WIDTH-1:0]          cycle_budget,
  input  logic                             load_valid,
  output logic                             load_ready,
  input  logic [DATA_WIDTH-1:0]            load_data,
  input  logic                             load_last,
  output logic                             imem_we,
  output logic [clog2(INSTR_MEM_SIZE)-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0]            imem_wdata,
  output logic                             cpu_reset,
  output logic                             cpu_enable,
  input  logic [31:0]                      cpu_pc,
  output logic                             done,
  output logic                             timeout,
  output logic                             halted,
  output logic [clog2(INSTR_MEM_SIZE):0]   words_loaded,
  output logic [BUDGET_WIDTH-1:0]          run_cycles
);

  localparam int AW = clog2(INSTR_MEM_SIZE);
  localparam logic [AW:0] PTR_LAST = (AW+1)'(INSTR_MEM_SIZE - 1);

  state_e                  state_q;
  logic [AW:0]             ptr_q;
  logic [BUDGET_WIDTH-1:0] budget_q;
  logic [BUDGET_WIDTH-1:0] run_q;
  logic [BUDGET_WIDTH-1:0] run_d;
  logic [BUDGET_WIDTH:0]   run_next_full;
  logic [FLAG_W-1:0]       flags_q;
  logic                    load_ready_q;
  logic                    cpu_reset_q;
  logic                    cpu_enable_q;
  logic                    done_q;

  logic accept;
  logic load_end;
  logic start_load;
  logic budget_hit;
  logic halt_hit;

  assign accept        = load_valid & load_ready_q;
  assign load_end      = accept & (load_last | (ptr_q == PTR_LAST));
  assign start_load    = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign run_d         = (&run_q) ? run_q : run_q + 1'b1;
  assign run_next_full = {1'b0, run_q} + 1'b1;
  assign budget_hit    = (|budget_q) && (run_next_full == {1'b0, budget_q});

  program_loader_halt_detector #(
    .ENABLE (HALT_DETECT)
  ) u_halt (
    .clock    (clock),
    .reset    (reset),
    .active_i (state_q == ST_RUN),
    .pc_i     (cpu_pc),
    .halt_o   (halt_hit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      budget_q     <= '0;
      run_q        <= '0;
      flags_q      <= '0;
      load_ready_q <= 1'b0;
      cpu_reset_q  <= 1'b0;
      cpu_enable_q <= 1'b0;
      done_q       <= 1'b0;
    end else if (start_load) begin
      state_q      <= ST_LOAD;
      ptr_q        <= '0;
      budget_q     <= cycle_budget;
      run_q        <= '0;
      flags_q      <= '0;
      load_ready_q <= 1'b1;
      cpu_reset_q  <= 1'b0;
      cpu_enable_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) ptr_q <= ptr_q + 1'b1;
          // CPU leaves reset on the same edge as the final write.
          if (load_end) begin
            state_q      <= ST_RUN;
            load_ready_q <= 1'b0;
            cpu_reset_q  <= 1'b1;
            cpu_enable_q <= 1'b1;
          end
        end
        ST_RUN: begin
          run_q <= run_d;
          if (halt_hit || budget_hit) begin
            state_q                <= ST_DONE;
            cpu_enable_q           <= 1'b0;
            done_q                 <= 1'b1;
            flags_q[FLAG_HALT]     <= halt_hit;
            flags_q[FLAG_TIMEOUT]  <= ~halt_hit;
          end
        end
        default: ;
      endcase
    end
  end

  assign load_ready   = load_ready_q;
  assign imem_we      = accept;
  assign imem_addr    = ptr_q[AW-1:0];
  assign imem_wdata   = load_data;
  assign cpu_reset    = cpu_reset_q;
  assign cpu_enable   = cpu_enable_q;
  assign done         = done_q;
  assign timeout      = flags_q[FLAG_TIMEOUT];
  assign halted       = flags_q[FLAG_HALT];
  assign words_loaded = ptr_q;
  assign run_cycles   = run_q;

endmodule
